// File: rtl/rb_pkg.sv
// Shared types and sizes for the register bank, its writeback front end and hazard unit.
// No logic here: constants, the writeback entry type and a one-hot decode helper.
// Backpressure: not applicable.
package rb_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 4;
    localparam int NREG     = 2 ** ADDR_W;
    localparam int WB_DEPTH = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // One-hot decode of a register index into a NREG-wide mask.
    function automatic logic [NREG-1:0] rd_onehot(input logic [ADDR_W-1:0] idx);
        return NREG'(1) << idx;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order FIFO of writeback entries with per-entry valid/rd taps for the busy mask.
// Latency: an entry pushed at edge k is visible at the head after edge k.
// Backpressure: caller must not push when full or pop when empty; flush wins over both.
module wb_fifo
    import rb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = PW + 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_push,
    input  wb_entry_t                     i_push_dat,
    input  logic                          i_pop,
    input  logic                          i_flush,
    output wb_entry_t                     o_head_dat,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [CW-1:0]                 o_count,
    output logic [DEPTH-1:0]              o_ent_vld,
    output logic [DEPTH-1:0][ADDR_W-1:0]  o_ent_rd
);

    wb_entry_t       r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    // Pointer/count bookkeeping and storage writes; flush empties the queue in one edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_full     = (r_count == CW'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;

    // A slot holds a live entry when its distance from the read pointer is below count.
    always_comb begin
        o_ent_vld = '0;
        o_ent_rd  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] off;
            off          = PW'(i) - r_rd_ptr;
            o_ent_vld[i] = ({1'b0, off} < r_count);
            o_ent_rd[i]  = r_mem[i].rd;
        end
    end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Arbitrates ALU/memory writebacks into a FIFO and drives the bank write port, one per cycle.
// Latency: accepted at edge k -> write presented after edge k+1, committed by the bank at k+2.
// Backpressure: readys drop when full or flushing; memory has fixed priority over ALU.
module reg_writeback_ctrl
    import rb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_mem_valid,
    output logic              o_mem_ready,
    input  logic [ADDR_W-1:0] i_mem_rd,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic              i_alu_valid,
    output logic              o_alu_ready,
    input  logic [ADDR_W-1:0] i_alu_rd,
    input  logic [DATA_W-1:0] i_alu_data,
    input  logic              i_hold,
    input  logic              i_flush,
    output logic              o_write,
    output logic [ADDR_W-1:0] o_write_port,
    output logic [DATA_W-1:0] o_write_data,
    output logic [NREG-1:0]   o_busy_mask
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic                         w_full;
    logic                         w_empty;
    logic [CW-1:0]                w_count;
    logic                         w_push;
    logic                         w_pop;
    wb_entry_t                    w_push_dat;
    wb_entry_t                    w_head;
    logic [DEPTH-1:0]             w_ent_vld;
    logic [DEPTH-1:0][ADDR_W-1:0] w_ent_rd;

    logic              r_write;
    logic [ADDR_W-1:0] r_write_port;
    logic [DATA_W-1:0] r_write_data;

    // Full is the pre-edge state, so a same-cycle pop never frees room for a push.
    assign o_mem_ready = i_rst_n && !w_full && !i_flush;
    assign o_alu_ready = i_rst_n && !w_full && !i_flush && !i_mem_valid;
    assign w_push      = (i_mem_valid && o_mem_ready) || (i_alu_valid && o_alu_ready);
    assign w_pop       = !w_empty && !i_hold && !i_flush;

    // Select the winning request's payload; memory wins whenever it is valid.
    always_comb begin
        w_push_dat = '0;
        if (i_mem_valid) begin
            w_push_dat.rd   = i_mem_rd;
            w_push_dat.data = i_mem_data;
        end else begin
            w_push_dat.rd   = i_alu_rd;
            w_push_dat.data = i_alu_data;
        end
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .i_flush    (i_flush),
        .o_head_dat (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count),
        .o_ent_vld  (w_ent_vld),
        .o_ent_rd   (w_ent_rd)
    );

    // Output register: strobe follows the pop; index/data hold their last value when idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_write      <= 1'b0;
            r_write_port <= '0;
            r_write_data <= '0;
        end else begin
            r_write <= w_pop;
            if (w_pop) begin
                r_write_port <= w_head.rd;
                r_write_data <= w_head.data;
            end
        end
    end

    assign o_write      = r_write;
    assign o_write_port = r_write_port;
    assign o_write_data = r_write_data;

    // Busy mask: every queued destination plus the one currently being presented.
    always_comb begin
        o_busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_ent_vld[i]) begin
                o_busy_mask = o_busy_mask | rd_onehot(w_ent_rd[i]);
            end
        end
        if (r_write) begin
            o_busy_mask = o_busy_mask | rd_onehot(r_write_port);
        end
    end

    // Occupancy sanity: count never exceeds depth and agrees with the empty flag.
    always @(posedge i_clk) begin
        if (i_rst_n) begin
            assert (w_count <= CW'(DEPTH));
            assert (w_empty == (w_count == '0));
        end
    end

endmodule
